// File: rtl/regfile_wren_guard_pkg.sv
// rtl/regfile_wren_guard_pkg.sv - shared defaults and error-cause bit indices for the write-enable guard
package regfile_wren_guard_pkg;

    localparam int DefAddrWidth = 5;

    localparam int NumCauses = 3;
    localparam int ErrAddr   = 2;
    localparam int ErrEn     = 1;
    localparam int ErrOh     = 0;

endpackage

// File: rtl/wren_icg_cell.sv
// rtl/wren_icg_cell.sv - latch-based integrated clock gate with scan override
module wren_icg_cell (
    input  logic clk_i,
    input  logic en_i,
    input  logic test_en_i,
    output logic clk_o
);

    logic r_en_latched;

    // Transparent while the clock is low so enable edges during the high phase cannot glitch clk_o.
    always_latch begin
        if (!clk_i) begin
            r_en_latched <= en_i | test_en_i;
        end
    end

    assign clk_o = clk_i & r_en_latched;

endmodule

// File: rtl/regfile_wren_guard.sv
// rtl/regfile_wren_guard.sv - one-hot write strobe encoder with consistency checks and two-level clock gating
module regfile_wren_guard
    import regfile_wren_guard_pkg::*;
#(
    parameter int AddrWidth   = DefAddrWidth,
    parameter int OneHotWidth = 2**AddrWidth,
    parameter bit AddrCheck   = 1'b1,
    parameter bit EnableCheck = 1'b1
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   test_en_i,
    input  logic                   en_i,
    input  logic [AddrWidth-1:0]   addr_i,
    input  logic [OneHotWidth-1:0] oh_flip_i,
    output logic [OneHotWidth-1:0] oh_o,
    output logic [OneHotWidth-1:0] gclk_o,
    output logic                   gclk_all_o,
    output logic                   err_o,
    output logic                   err_sticky_o,
    output logic [NumCauses-1:0]   err_cause_o
);

    if (AddrCheck && !EnableCheck) begin : g_bad_check_cfg
        $error("regfile_wren_guard: AddrCheck=1 requires EnableCheck=1");
    end

    if (OneHotWidth < 2 || OneHotWidth > 2**AddrWidth) begin : g_bad_width_cfg
        $error("regfile_wren_guard: OneHotWidth must lie in 2..2**AddrWidth");
    end

    logic [OneHotWidth-1:0] w_oh_raw;
    logic [OneHotWidth-1:0] w_oh;
    logic                   w_addr_in_range;
    logic                   w_oh_at_addr;
    logic [NumCauses-1:0]   w_cause;
    logic [NumCauses-1:0]   r_err_cause;
    logic                   w_gclk_all;

    assign w_addr_in_range = ({1'b0, addr_i} < (AddrWidth + 1)'(OneHotWidth));

    always_comb begin
        w_oh_raw = '0;
        for (int i = 0; i < OneHotWidth; i++) begin
            if (addr_i == AddrWidth'(i)) begin
                w_oh_raw[i] = en_i;
            end
        end
    end

    assign w_oh = w_oh_raw ^ oh_flip_i;

    // Addressed bit of the post-injection vector; stays 0 when the address is out of range.
    always_comb begin
        w_oh_at_addr = 1'b0;
        for (int i = 0; i < OneHotWidth; i++) begin
            if (addr_i == AddrWidth'(i)) begin
                w_oh_at_addr = w_oh[i];
            end
        end
    end

    always_comb begin
        w_cause        = '0;
        w_cause[ErrOh] = !$onehot0(w_oh);
        if (EnableCheck) begin
            w_cause[ErrEn] = en_i ? (w_oh == '0) : (w_oh != '0);
        end
        if (AddrCheck) begin
            w_cause[ErrAddr] = !w_addr_in_range || (en_i && !w_oh_at_addr);
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_err_cause <= '0;
        end else begin
            r_err_cause <= r_err_cause | w_cause;
        end
    end

    assign oh_o         = w_oh;
    assign err_o        = |w_cause;
    assign err_cause_o  = r_err_cause;
    assign err_sticky_o = |r_err_cause;

    wren_icg_cell u_icg_all (
        .clk_i     (clk_i),
        .en_i      (en_i),
        .test_en_i (test_en_i),
        .clk_o     (w_gclk_all)
    );

    assign gclk_all_o = w_gclk_all;

    // Word gates hang off the global gated clock so an idle cycle stops the whole tree at the root.
    for (genvar g = 0; g < OneHotWidth; g++) begin : g_word_icg
        wren_icg_cell u_icg_word (
            .clk_i     (w_gclk_all),
            .en_i      (w_oh[g]),
            .test_en_i (test_en_i),
            .clk_o     (gclk_o[g])
        );
    end

endmodule

// File: tb/tb_regfile_wren_guard.sv
// tb/tb_regfile_wren_guard.sv - directed and randomized self-checking bench for regfile_wren_guard
module tb_regfile_wren_guard;

    logic        clk_i;
    logic        rst_i;
    logic        test_en_i;
    logic        en_i;
    logic [4:0]  addr_i;
    logic [31:0] oh_flip_i;
    logic [31:0] oh_o;
    logic [31:0] gclk_o;
    logic        gclk_all_o;
    logic        err_o;
    logic        err_sticky_o;
    logic [2:0]  err_cause_o;

    int          n_pass  = 0;
    int          n_total = 0;
    logic [2:0]  m_cause = 3'b000;

    regfile_wren_guard dut (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .test_en_i    (test_en_i),
        .en_i         (en_i),
        .addr_i       (addr_i),
        .oh_flip_i    (oh_flip_i),
        .oh_o         (oh_o),
        .gclk_o       (gclk_o),
        .gclk_all_o   (gclk_all_o),
        .err_o        (err_o),
        .err_sticky_o (err_sticky_o),
        .err_cause_o  (err_cause_o)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_total++;
        assert (got === exp) n_pass++;
        else $error("FAIL %s observed=%h expected=%h", tag, got, exp);
    endtask

    function automatic logic [31:0] model_oh(input logic e, input logic [4:0] a, input logic [31:0] f);
        logic [31:0] raw;
        raw = e ? (32'd1 << a) : 32'd0;
        return raw ^ f;
    endfunction

    function automatic logic [2:0] model_cause(input logic e, input logic [4:0] a, input logic [31:0] f);
        logic [31:0] o;
        logic [2:0]  c;
        o    = model_oh(e, a, f);
        c[2] = e && (o[a] == 1'b0);
        c[1] = e ? (o == 32'd0) : (o != 32'd0);
        c[0] = $countones(o) > 1;
        return c;
    endfunction

    task automatic step(input string tag, input logic e, input logic [4:0] a,
                        input logic [31:0] f, input logic t, input logic drop_rst);
        logic [31:0] o;
        logic [2:0]  c;
        logic        ga;
        logic [31:0] gv;
        @(negedge clk_i);
        en_i      = e;
        addr_i    = a;
        oh_flip_i = f;
        test_en_i = t;
        if (drop_rst) rst_i = 1'b0;
        #1;
        o = model_oh(e, a, f);
        c = model_cause(e, a, f);
        chk({tag, ".oh"}, 64'(oh_o), 64'(o));
        chk({tag, ".err"}, 64'(err_o), 64'(|c));
        chk({tag, ".gclk_low"}, {31'd0, gclk_all_o, gclk_o}, 64'd0);
        @(posedge clk_i);
        #1;
        m_cause = m_cause | c;
        ga = e | t;
        gv = ga ? (o | {32{t}}) : 32'd0;
        chk({tag, ".gclk_all"}, 64'(gclk_all_o), 64'(ga));
        chk({tag, ".gclk"}, 64'(gclk_o), 64'(gv));
        chk({tag, ".cause"}, 64'(err_cause_o), 64'(m_cause));
        chk({tag, ".sticky"}, 64'(err_sticky_o), 64'(|m_cause));
    endtask

    // Raises reset in the high phase and leaves it asserted; the next step releases it.
    task automatic reset_mid(input string tag);
        #2;
        rst_i = 1'b1;
        #1;
        m_cause = 3'b000;
        chk({tag, ".rst_cause"}, 64'(err_cause_o), 64'd0);
        chk({tag, ".rst_sticky"}, 64'(err_sticky_o), 64'd0);
    endtask

    initial begin
        logic        pend_rst;
        logic [31:0] f;
        rst_i     = 1'b1;
        test_en_i = 1'b0;
        en_i      = 1'b0;
        addr_i    = 5'd0;
        oh_flip_i = 32'd0;
        #2;
        chk("reset.cause", 64'(err_cause_o), 64'd0);
        chk("reset.sticky", 64'(err_sticky_o), 64'd0);
        oh_flip_i = 32'd1;
        #1;
        chk("reset.err_live", 64'(err_o), 64'd1);
        chk("reset.oh_live", 64'(oh_o), 64'd1);
        @(posedge clk_i);
        #1;
        chk("reset.hold_cause", 64'(err_cause_o), 64'd0);

        step("req041_release", 1'b0, 5'd9, 32'h1, 1'b0, 1'b1);
        chk("req041.cause_const", 64'(err_cause_o), 64'h2);
        chk("req041.sticky_const", 64'(err_sticky_o), 64'd1);

        reset_mid("req045");
        step("req040", 1'b1, 5'd5, 32'h0, 1'b0, 1'b1);
        chk("req040.oh_const", 64'(oh_o), 64'h20);
        chk("req040.gclk_const", 64'(gclk_o), 64'h20);
        chk("req040.sticky_const", 64'(err_sticky_o), 64'd0);

        step("req042", 1'b1, 5'd3, 32'h10, 1'b0, 1'b0);
        chk("req042.oh_const", 64'(oh_o), 64'h18);
        chk("req042.cause_const", 64'(err_cause_o), 64'h1);

        reset_mid("pre043");
        step("req043", 1'b1, 5'd3, 32'h18, 1'b0, 1'b1);
        chk("req043.oh_const", 64'(oh_o), 64'h10);
        chk("req043.cause_const", 64'(err_cause_o), 64'h4);

        reset_mid("pre044");
        step("req044", 1'b0, 5'd17, 32'h0, 1'b1, 1'b1);
        chk("req044.gclk_const", 64'(gclk_o), 64'hFFFF_FFFF);
        chk("req044.err_const", 64'(err_o), 64'd0);
        step("addr0", 1'b1, 5'd0, 32'h0, 1'b0, 1'b0);
        step("addr31", 1'b1, 5'd31, 32'h0, 1'b0, 1'b0);
        step("idle", 1'b0, 5'd12, 32'h0, 1'b0, 1'b0);
        step("flip_addr0", 1'b1, 5'd0, 32'h1, 1'b0, 1'b0);

        pend_rst = 1'b0;
        for (int i = 0; i < 300; i++) begin
            case ($urandom_range(0, 3))
                0, 1:    f = 32'd0;
                2:       f = 32'd1 << $urandom_range(0, 31);
                default: f = $urandom;
            endcase
            step("rand", 1'($urandom), 5'($urandom), f,
                 $urandom_range(0, 7) == 0, pend_rst);
            pend_rst = 1'b0;
            if (i % 25 == 24) begin
                reset_mid("rand");
                pend_rst = 1'b1;
            end
        end
        if (pend_rst) step("final", 1'b0, 5'd0, 32'h0, 1'b0, 1'b1);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
